// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_pkg
// Brief    : Shared ALU definitions: add-mode encoding and the width check.
// Revision : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } add_mode_e;

    // WIDTH must split into STAGES equal chunks.
    function automatic bit width_ok(input int unsigned width, input int unsigned stages);
        return (stages != 0) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ============================================================================
// Module   : adder_chunk
// Brief    : C-bit ripple adder of fulladder cells; also exposes MSB carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module adder_chunk #(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] sum,
    output logic         co,
    output logic         c_msb_in
);

    logic [C:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < C; i++) begin : g_bit
        fulladder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co       = c[C];
    assign c_msb_in = c[C-1];

endmodule
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
// Module   : fulladder
// Brief    : One-bit full adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : WIDTH-bit add/subtract split into STAGES carry-chained chunks.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int C = WIDTH / STAGES;

    if (!width_ok(WIDTH, STAGES)) begin : g_width_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic [STAGES-1:0] valid_q, carry_q, msb_q, sub_q, sm_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  x_q   [STAGES];
    logic [WIDTH-1:0]  yy_q  [STAGES];

    // Per-stage inputs: port values for stage 0, previous stage registers otherwise.
    logic [WIDTH-1:0]  st_x   [STAGES];
    logic [WIDTH-1:0]  st_y   [STAGES];
    logic [WIDTH-1:0]  st_sum [STAGES];
    logic [WIDTH-1:0]  nxt_sum[STAGES];
    logic [C-1:0]      ch_sum [STAGES];
    logic [STAGES-1:0] st_c, st_sub, st_sm, st_v, ch_co, ch_msb;
    logic              adv;
    logic              c_out;
    logic              unused_tail;

    assign adv      = out_ready || !valid_q[STAGES-1];
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_x[k]   = x;
            assign st_y[k]   = (sub == SUB) ? ~y : y;
            assign st_c[k]   = (sub == SUB) ? ~cin : cin;
            assign st_sub[k] = sub;
            assign st_sm[k]  = signed_mode;
            assign st_v[k]   = in_valid;
            assign st_sum[k] = '0;
        end else begin : g_next
            assign st_x[k]   = x_q[k-1];
            assign st_y[k]   = yy_q[k-1];
            assign st_c[k]   = carry_q[k-1];
            assign st_sub[k] = sub_q[k-1];
            assign st_sm[k]  = sm_q[k-1];
            assign st_v[k]   = valid_q[k-1];
            assign st_sum[k] = sum_q[k-1];
        end

        adder_chunk #(
            .C (C)
        ) u_chunk (
            .a        (st_x[k][k*C +: C]),
            .b        (st_y[k][k*C +: C]),
            .ci       (st_c[k]),
            .sum      (ch_sum[k]),
            .co       (ch_co[k]),
            .c_msb_in (ch_msb[k])
        );

        // Chunk k's bit positions are still zero in the partial sum arriving here.
        assign nxt_sum[k] = st_sum[k] | (WIDTH'(ch_sum[k]) << (k * C));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            msb_q   <= '0;
            sub_q   <= '0;
            sm_q    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                x_q[k]   <= '0;
                yy_q[k]  <= '0;
            end
        end else if (adv) begin
            valid_q <= st_v;
            carry_q <= ch_co;
            msb_q   <= ch_msb;
            sub_q   <= st_sub;
            sm_q    <= st_sm;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k] <= nxt_sum[k];
                x_q[k]   <= st_x[k];
                yy_q[k]  <= st_y[k];
            end
        end
    end

    assign c_out     = carry_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign s         = sum_q[STAGES-1];
    assign cout      = sub_q[STAGES-1] ? ~c_out : c_out;
    assign ovf       = sm_q[STAGES-1] ? (msb_q[STAGES-1] ^ c_out) : cout;

    // Last-stage operand copies and early MSB carries have no consumer.
    assign unused_tail = ^{msb_q, x_q[STAGES-1], yy_q[STAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Brief    : Directed self-checking bench for pipelined_adder (16 bits, 4 stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] x, y;
    logic        cin, sub, signed_mode;
    logic        out_valid, out_ready;
    logic [15:0] s;
    logic        cout, ovf;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_r [8];
    logic [15:0] sx [5];
    logic [15:0] sy [5];
    logic        ssub [5];

    pipelined_adder #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x           (x),
        .y           (y),
        .cin         (cin),
        .sub         (sub),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .s           (s),
        .cout        (cout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, cout, s} from plain wide arithmetic.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb, input logic sm);
        logic [15:0] bb;
        logic        c0, co, ov;
        logic [16:0] full;
        logic [15:0] low;
        bb   = sb ? ~b : b;
        c0   = sb ? ~ci : ci;
        full = {1'b0, a} + {1'b0, bb} + 17'(c0);
        low  = {1'b0, a[14:0]} + {1'b0, bb[14:0]} + 16'(c0);
        co   = sb ? ~full[16] : full[16];
        ov   = sm ? (low[15] ^ full[16]) : co;
        return {ov, co, full[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input logic sm, input logic v);
        x = a; y = b; cin = ci; sub = sb; signed_mode = sm; in_valid = v;
    endtask

    // One isolated beat: checks latency and the result fields.
    task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic sb, input logic sm,
                            input logic [15:0] es, input logic ec, input logic eo);
        drive(a, b, ci, sb, sm, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 3) chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"},     32'(s),         32'(es));
        chk({tag, "_cout"},  32'(cout),      32'(ec));
        chk({tag, "_ovf"},   32'(ovf),       32'(eo));
        @(posedge clk); #1;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s",         32'(s),         32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        send_one("sadd_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        send_one("sadd_neg",   16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        send_one("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        send_one("sub_bin",    16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

        // Back-to-back stream: results in consecutive cycles 3..10 after the first accept.
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                logic [15:0] a, b;
                logic ci, sb, sm;
                a  = 16'($urandom);
                b  = 16'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                sm = 1'($urandom);
                exp_r[i] = model(a, b, ci, sb, sm);
                drive(a, b, ci, sb, sm, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'((i >= 3) && (i <= 10)));
            if ((i >= 3) && (i <= 10))
                chk("stream_result", 32'({ovf, cout, s}), 32'(exp_r[i-3]));
        end
        in_valid = 1'b0;

        // Fill the pipe, stall three cycles with a beat waiting, then release.
        sx[0] = 16'h1000; sy[0] = 16'h0234; ssub[0] = 1'b0;
        sx[1] = 16'h2222; sy[1] = 16'h1111; ssub[1] = 1'b0;
        sx[2] = 16'hF0F0; sy[2] = 16'h0F10; ssub[2] = 1'b1;
        sx[3] = 16'h8000; sy[3] = 16'h8000; ssub[3] = 1'b0;
        sx[4] = 16'h0F0F; sy[4] = 16'h7070; ssub[4] = 1'b0;
        for (int i = 0; i < 5; i++) exp_r[i] = model(sx[i], sy[i], 1'b0, ssub[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(sx[i], sy[i], 1'b0, ssub[i], 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        chk("stall_head_valid", 32'(out_valid), 32'd1);
        chk("stall_head", 32'({ovf, cout, s}), 32'(exp_r[0]));
        out_ready = 1'b0;
        drive(sx[4], sy[4], 1'b0, ssub[4], 1'b0, 1'b1);
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_hold",     32'({ovf, cout, s}), 32'(exp_r[0]));
            chk("stall_in_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk); #1;
            if (j == 1) in_valid = 1'b0;
            chk("release_valid",  32'(out_valid), 32'd1);
            chk("release_result", 32'({ovf, cout, s}), 32'(exp_r[j]));
        end
        @(posedge clk); #1;
        chk("release_drained", 32'(out_valid), 32'd0);

        // Reset with beats in flight and one at the output.
        for (int i = 0; i < 4; i++) begin
            drive(sx[i], sy[i], 1'b0, ssub[i], 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_s",     32'(s),         32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_reset_no_stale", 32'(out_valid), 32'd0);
        end
        send_one("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
